read_scheduler: RTL and testbench

READ_SCHEDULER -- requirements
Module: read_scheduler

---
 rtl/sched_pkg.sv | 39 +++
 rtl/tick_gen.sv | 30 +++
 rtl/read_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_read_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the read scheduler: queue geometry, FSM state
// encoding and the one-hot dequeue request codes driven onto 'reading'.
package sched_pkg;

  localparam int NUMQ   = 4;
  localparam int QDEPTH = 6;
  localparam int QIDX_W = $clog2(NUMQ);
  localparam int OCC_W  = $clog2(QDEPTH + 1);

  // Ingress strobe phase on which the buffer stage acknowledges a dequeue.
  localparam logic [2:0] ACK_PHASE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_RETIRE = 2'd3
  } sched_state_t;

  localparam logic [3:0] RD_IDLE = 4'd0;
  localparam logic [3:0] RD_Q1   = 4'd1;
  localparam logic [3:0] RD_Q2   = 4'd2;
  localparam logic [3:0] RD_Q3   = 4'd4;
  localparam logic [3:0] RD_Q4   = 4'd8;

  // Map a zero-based queue index to its one-hot dequeue request.
  function automatic logic [3:0] read_code(input logic [QIDX_W-1:0] q);
    logic [3:0] code;
    case (q)
      2'd0:    code = RD_Q1;
      2'd1:    code = RD_Q2;
      2'd2:    code = RD_Q3;
      2'd3:    code = RD_Q4;
      default: code = RD_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running service tick generator: counts 0..TICK_DIV-1 and raises
// 'tick' for exactly the one cycle in which the counter sits at its top
// value, i.e. the cycle just before it wraps back to zero.
module tick_gen #(
  parameter int TICK_DIV = 150000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // Divider counter, cleared by reset and on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/read_scheduler.sv
// Read scheduler: on every service tick, picks the fullest of four queues
// and holds a one-hot dequeue request until the buffer stage acknowledges
// it (count == 4). Each completed dequeue pulses tx_valid, reports
// {queue, head payload} on tx_data and bumps that queue's counter.
//
// Build option: define SCHED_RR_EN to break ties on the largest occupancy
// round-robin (search starts after the last served queue). Without it,
// ties go to the lowest queue index and no pointer register exists.
module read_scheduler
  import sched_pkg::*;
#(
  parameter int TICK_DIV = 150000000,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OCC_W-1:0]  count1,
  input  logic [OCC_W-1:0]  count2,
  input  logic [OCC_W-1:0]  count3,
  input  logic [OCC_W-1:0]  count4,
  input  logic [11:0]       buffer1,
  input  logic [11:0]       buffer2,
  input  logic [11:0]       buffer3,
  input  logic [11:0]       buffer4,
  input  logic [2:0]        count,
  output logic [3:0]        reading,
  output logic [3:0]        tx_data,
  output logic              tx_valid,
  output logic [CNT_W-1:0]  transmitted1,
  output logic [CNT_W-1:0]  transmitted2,
  output logic [CNT_W-1:0]  transmitted3,
  output logic [CNT_W-1:0]  transmitted4
);

  logic tick;
  logic ack;

  sched_state_t state;
  sched_state_t state_next;
  logic         pending;
  logic         pending_next;
  logic [QIDX_W-1:0] sel;
  logic [QIDX_W-1:0] sel_next;
  logic [3:0]   tx_data_next;

  logic [OCC_W-1:0]  occ  [NUMQ];
  logic [1:0]        head [NUMQ];
  logic [CNT_W-1:0]  xmit [NUMQ];

  logic [QIDX_W-1:0] rr_start;
  logic [QIDX_W-1:0] best_idx;
  logic [QIDX_W-1:0] cand;
  logic [OCC_W-1:0]  best_occ;
  logic              best_found;

  // Only the head entry of each buffer matters here; the rest of each
  // buffer is folded into a sink so the unused bits are accounted for.
  logic unused_buf_bits;
  assign unused_buf_bits = ^{buffer1[9:0], buffer2[9:0], buffer3[9:0], buffer4[9:0]};

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign ack = (count == ACK_PHASE);

  assign occ[0]  = count1;
  assign occ[1]  = count2;
  assign occ[2]  = count3;
  assign occ[3]  = count4;
  assign head[0] = buffer1[11:10];
  assign head[1] = buffer2[11:10];
  assign head[2] = buffer3[11:10];
  assign head[3] = buffer4[11:10];

`ifdef SCHED_RR_EN
  logic [QIDX_W-1:0] rr_ptr;

  // Round-robin start pointer: moves to the queue after the one just
  // served, and only when the dequeue is actually acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((state == S_ISSUE) && ack) begin
      rr_ptr <= sel + QIDX_W'(1);
    end
  end

  assign rr_start = rr_ptr;
`else
  assign rr_start = '0;
`endif

  // Largest-occupancy search; scanning from rr_start with a strict
  // comparison makes the first queue in scan order win any tie.
  always_comb begin
    best_found = 1'b0;
    best_idx   = rr_start;
    best_occ   = '0;
    cand       = rr_start;
    for (int i = 0; i < NUMQ; i++) begin
      cand = rr_start + QIDX_W'(i);
      if (occ[cand] > best_occ) begin
        best_occ   = occ[cand];
        best_idx   = cand;
        best_found = 1'b1;
      end
    end
  end

  // Next-state logic; ticks that arrive while busy collapse into a single
  // pending flag, so at most one extra service is remembered.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    sel_next     = sel;
    tx_data_next = tx_data;
    case (state)
      S_IDLE: begin
        if (tick || pending) begin
          state_next   = S_SELECT;
          pending_next = 1'b0;
        end
      end
      S_SELECT: begin
        if (tick) begin
          pending_next = 1'b1;
        end
        if (best_found) begin
          sel_next     = best_idx;
          tx_data_next = {best_idx, head[best_idx]};
          state_next   = S_ISSUE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (tick) begin
          pending_next = 1'b1;
        end
        if (ack) begin
          state_next = S_RETIRE;
        end
      end
      S_RETIRE: begin
        if (tick) begin
          pending_next = 1'b1;
        end
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Control registers; tx_valid is high during the RETIRE cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pending  <= 1'b0;
      sel      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      sel      <= sel_next;
      tx_data  <= tx_data_next;
      tx_valid <= (state == S_ISSUE) && ack;
    end
  end

  // Served-packet counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUMQ; i++) begin
        xmit[i] <= '0;
      end
    end else if ((state == S_ISSUE) && ack) begin
      xmit[sel] <= xmit[sel] + CNT_W'(1);
    end
  end

  assign reading      = (state == S_ISSUE) ? read_code(sel) : RD_IDLE;
  assign transmitted1 = xmit[0];
  assign transmitted2 = xmit[1];
  assign transmitted3 = xmit[2];
  assign transmitted4 = xmit[3];

  // At most one dequeue request is ever raised at a time.
  a_reading_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(reading));

  // A completion pulse never overlaps a live request.
  a_valid_idle: assert property (@(posedge clk) disable iff (rst) tx_valid |-> (reading == RD_IDLE));

endmodule

// File: tb/tb_read_scheduler.sv
// Bench for read_scheduler with an 8-cycle tick and 4-bit counters so that
// counter wrap is reachable quickly. The reference model works per service
// transaction: the queue to serve is the one with the maximum occupancy,
// ties resolved from a start index (last served + 1 with SCHED_RR_EN,
// otherwise queue 1). Tick timing is known from the cycle count since reset.
module tb_read_scheduler;

  localparam int TICK_DIV = 8;
  localparam int CNT_W    = 4;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]  count1 = '0, count2 = '0, count3 = '0, count4 = '0;
  logic [11:0] buffer1 = '0, buffer2 = '0, buffer3 = '0, buffer4 = '0;
  logic [2:0]  count = '0;
  logic [3:0]  reading;
  logic [3:0]  tx_data;
  logic        tx_valid;
  logic [CNT_W-1:0] transmitted1, transmitted2, transmitted3, transmitted4;

  read_scheduler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .count1       (count1),
    .count2       (count2),
    .count3       (count3),
    .count4       (count4),
    .buffer1      (buffer1),
    .buffer2      (buffer2),
    .buffer3      (buffer3),
    .buffer4      (buffer4),
    .count        (count),
    .reading      (reading),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .transmitted1 (transmitted1),
    .transmitted2 (transmitted2),
    .transmitted3 (transmitted3),
    .transmitted4 (transmitted4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          qCount [4];
  logic [11:0] qBuf   [4];
  int          modelTx[4];
  int          rrPtr;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the queue occupancy/buffer inputs from the bench's queue arrays.
  task automatic applyStimulus();
    count1  = 3'(qCount[0]);
    count2  = 3'(qCount[1]);
    count3  = 3'(qCount[2]);
    count4  = 3'(qCount[3]);
    buffer1 = qBuf[0];
    buffer2 = qBuf[1];
    buffer3 = qBuf[2];
    buffer4 = qBuf[3];
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) modelTx[i] = 0;
    rrPtr = 0;
  endtask

  // Two reset edges; afterwards the current cycle is cycle 0 of the divider.
  task automatic doReset();
    rst   = 1'b1;
    count = 3'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    resetModel();
  endtask

  function automatic logic [2:0] nonAck();
    int v;
    v = $urandom_range(0, 6);
    if (v >= 4) v++;
    return 3'(v);
  endfunction

  // Queue the scheduler should pick now, or -1 when every queue is empty.
  function automatic int expectedQueue();
    int best;
    int start;
    best = 0;
`ifdef SCHED_RR_EN
    start = rrPtr;
`else
    start = 0;
`endif
    for (int i = 0; i < 4; i++) if (qCount[i] > best) best = qCount[i];
    if (best == 0) return -1;
    for (int i = 0; i < 4; i++) if (qCount[(start + i) % 4] == best) return (start + i) % 4;
    return -1;
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_tx1"}, 32'(transmitted1), 32'(modelTx[0] & CNT_MASK));
    checkOutput({tag, "_tx2"}, 32'(transmitted2), 32'(modelTx[1] & CNT_MASK));
    checkOutput({tag, "_tx3"}, 32'(transmitted3), 32'(modelTx[2] & CNT_MASK));
    checkOutput({tag, "_tx4"}, 32'(transmitted4), 32'(modelTx[3] & CNT_MASK));
  endtask

  // Step until a request appears (bounded); the strobe is random, including
  // the ack value, which must be ignored while no request is raised.
  task automatic waitReading(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (reading == 4'd0 && n < maxCycles) begin
      count = 3'($urandom_range(0, 7));
      stepCycle();
      n++;
      checkOutput({tag, "_novalid"}, 32'(tx_valid), 32'd0);
    end
    count = 3'd0;
    checkOutput({tag, "_seen"}, 32'(reading != 4'd0), 32'd1);
  endtask

  // Called while a request is raised: hold it, acknowledge, check completion.
  task automatic ackAndCheck(input string tag, input int hold);
    int k;
    logic [3:0] expTx;
    k = expectedQueue();
    if (k < 0) k = 0;
    checkOutput({tag, "_reading"}, 32'(reading), 32'(1 << k));
    for (int h = 0; h < hold; h++) begin
      count = nonAck();
      stepCycle();
      checkOutput({tag, "_hold"}, 32'(reading), 32'(1 << k));
      checkOutput({tag, "_holdvalid"}, 32'(tx_valid), 32'd0);
    end
    count = 3'd4;
    stepCycle();
    count = 3'd0;
    modelTx[k] = (modelTx[k] + 1) & CNT_MASK;
    rrPtr = (k + 1) % 4;
    expTx = {2'(k), qBuf[k][11:10]};
    checkOutput({tag, "_txvalid"}, 32'(tx_valid), 32'd1);
    checkOutput({tag, "_rdidle"}, 32'(reading), 32'd0);
    checkOutput({tag, "_txdata"}, 32'(tx_data), 32'(expTx));
    checkCounters(tag);
    stepCycle();
    checkOutput({tag, "_pulse"}, 32'(tx_valid), 32'd0);
  endtask

  // Hard stop in case the bench itself stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    int r;
    int expK;

    for (int i = 0; i < 4; i++) begin
      qCount[i] = 0;
      qBuf[i]   = 12'h000;
    end
    applyStimulus();
    doReset();

    // Reset state.
    checkOutput("rst_reading", 32'(reading), 32'd0);
    checkOutput("rst_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_txdata", 32'(tx_data), 32'd0);
    checkCounters("rst");

    // Basic service with exact tick-to-request latency: tick in cycle 7,
    // request from cycle 9, ack two cycles after the request appears.
    qCount[0] = 2; qCount[1] = 5; qCount[2] = 1; qCount[3] = 0;
    qBuf[0] = 12'($urandom_range(0, 4095));
    qBuf[1] = 12'hC00 | 12'($urandom_range(0, 1023));
    qBuf[2] = 12'($urandom_range(0, 4095));
    qBuf[3] = 12'($urandom_range(0, 4095));
    applyStimulus();
    while (cyc < 9) begin
      checkOutput("lat_early", 32'(reading), 32'd0);
      stepCycle();
    end
    checkOutput("lat_first", 32'(reading), 32'd2);
    stepCycle();
    checkOutput("lat_hold1", 32'(reading), 32'd2);
    stepCycle();
    ackAndCheck("basic", 0);
    checkOutput("basic_txdata_lit", 32'(tx_data), 32'h7);
    checkOutput("basic_tx2_lit", 32'(transmitted2), 32'd1);

    // All queues empty across three ticks: no request, no pulse, tx_data held.
    for (int i = 0; i < 4; i++) qCount[i] = 0;
    applyStimulus();
    for (int i = 0; i < 3 * TICK_DIV + 2; i++) begin
      count = 3'($urandom_range(0, 7));
      stepCycle();
      checkOutput("empty_reading", 32'(reading), 32'd0);
      checkOutput("empty_valid", 32'(tx_valid), 32'd0);
    end
    count = 3'd0;
    checkOutput("empty_txdata_held", 32'(tx_data), 32'h7);
    checkCounters("empty");

    // Four-way tie from reset: rotation with SCHED_RR_EN, else queue 1 only.
    doReset();
    for (int i = 0; i < 4; i++) begin
      qCount[i] = 3;
      qBuf[i]   = 12'($urandom_range(0, 4095));
    end
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      waitReading("tie", 3 * TICK_DIV);
`ifdef SCHED_RR_EN
      expK = i;
`else
      expK = 0;
`endif
      checkOutput("tie_order", 32'(reading), 32'(1 << expK));
      ackAndCheck("tie", $urandom_range(0, 2));
    end

    // Withheld ack: request held >= 20 cycles over several ticks, then
    // exactly one extra service before the next natural tick.
    qCount[0] = 0; qCount[1] = 5; qCount[2] = 1; qCount[3] = 1;
    applyStimulus();
    waitReading("stall", 3 * TICK_DIV);
    r = cyc;
    while (!(cyc >= r + 20 && (cyc % TICK_DIV) == 0)) begin
      count = nonAck();
      stepCycle();
      checkOutput("stall_hold", 32'(reading), 32'd2);
    end
    a = cyc;
    ackAndCheck("stall", 0);
    stepCycle();
    checkOutput("stall_gap", 32'(reading), 32'd0);
    stepCycle();
    checkOutput("stall_extra_cyc", 32'(cyc - a), 32'd4);
    checkOutput("stall_extra", 32'(reading), 32'd2);
    ackAndCheck("extra", 0);
    checkOutput("extra_idle0", 32'(reading), 32'd0);
    stepCycle();
    checkOutput("extra_idle1", 32'(reading), 32'd0);
    stepCycle();
    checkOutput("extra_idle2", 32'(reading), 32'd0);
    stepCycle();
    checkOutput("next_tick_cyc", 32'(cyc - a), 32'd9);
    checkOutput("next_tick", 32'(reading), 32'd2);
    ackAndCheck("next", 0);

    // Reset while a request is raised, with a tick already pending and an
    // ack in the same cycle: reset wins and the pending tick is discarded.
    qCount[0] = 0; qCount[1] = 0; qCount[2] = 6; qCount[3] = 0;
    applyStimulus();
    waitReading("midrst", 3 * TICK_DIV);
    do begin
      count = nonAck();
      stepCycle();
      checkOutput("midrst_hold", 32'(reading), 32'd4);
    end while ((cyc % TICK_DIV) != 0);
    rst   = 1'b1;
    count = 3'd4;
    stepCycle();
    rst   = 1'b0;
    count = 3'd0;
    cyc   = 0;
    resetModel();
    checkOutput("midrst_reading", 32'(reading), 32'd0);
    checkOutput("midrst_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst_txdata", 32'(tx_data), 32'd0);
    checkCounters("midrst");
    for (int c = 0; c < 9; c++) begin
      checkOutput("postrst_reading", 32'(reading), 32'd0);
      checkOutput("postrst_valid", 32'(tx_valid), 32'd0);
      stepCycle();
    end
    checkOutput("postrst_first", 32'(reading), 32'd4);
    ackAndCheck("postrst", 0);

    // Counter wrap on queue 1: fifteen services then one more returns to 0.
    qCount[0] = 6; qCount[1] = 0; qCount[2] = 0; qCount[3] = 0;
    qBuf[0] = 12'($urandom_range(0, 4095));
    applyStimulus();
    for (int i = 0; i < 16; i++) begin
      waitReading("wrap", 3 * TICK_DIV);
      ackAndCheck("wrap", $urandom_range(0, 2));
      if (i == 14) checkOutput("wrap_top", 32'(transmitted1), 32'd15);
    end
    checkOutput("wrap_zero", 32'(transmitted1), 32'd0);

    // Randomized rounds, biased toward ties and occasional empty rounds.
    for (int rnd = 0; rnd < 40; rnd++) begin
      for (int q = 0; q < 4; q++) begin
        qCount[q] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2) : $urandom_range(0, 6);
        qBuf[q]   = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 7) == 0) begin
        for (int q = 0; q < 4; q++) qCount[q] = 0;
      end
      applyStimulus();
      if (expectedQueue() < 0) begin
        for (int i = 0; i < 2 * TICK_DIV + 4; i++) begin
          count = 3'($urandom_range(0, 7));
          stepCycle();
          checkOutput("rnd_empty_reading", 32'(reading), 32'd0);
          checkOutput("rnd_empty_valid", 32'(tx_valid), 32'd0);
        end
        count = 3'd0;
      end else begin
        waitReading("rnd", 3 * TICK_DIV);
        ackAndCheck("rnd", $urandom_range(0, 12));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
